// File: rtl/exp_fix_collector.sv
// Collects exp-engine results on each rise of done, converts IEEE-754 single to
// saturating signed Q16.16, and buffers them for a valid/ready consumer.
module exp_fix_collector #(
  parameter int FIFO_DEPTH = 2,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [31:0]       result,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [31:0]       q_out,
  output logic              sat_out,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 2;

  logic          done_d;
  logic          req;
  logic          pop;
  logic          push;
  logic          accept;
  logic [OW-1:0] occ;

  logic          s1_v;
  logic [31:0]   s1_r;
  logic          s2_v;
  logic [31:0]   s2_q;
  logic          s2_sat;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [32:0]   head;

  // Conversion datapath signals
  logic          cv_s;
  logic [7:0]    cv_e;
  logic [23:0]   cv_mag;
  logic [31:0]   cv_abs;
  logic [31:0]   cv_shr;
  logic          cv_rbit;
  logic [31:0]   cv_q;
  logic          cv_sat;
  logic          cv_forced;

  assign req  = done & ~done_d;
  assign pop  = valid_out & ready_out;
  assign push = s2_v;

  // In-flight stages hold a reserved slot so a push can never find the FIFO full.
  assign occ    = OW'(count) + OW'(s1_v) + OW'(s2_v) - OW'(pop);
  assign accept = req && (occ < OW'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_d <= 1'b0;
    end else begin
      done_d <= done;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (req && !accept && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s1_r <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_r <= result;
      end
    end
  end

  always_comb begin
    cv_s      = s1_r[31];
    cv_e      = s1_r[30:23];
    cv_mag    = {1'b1, s1_r[22:0]};
    cv_abs    = '0;
    cv_shr    = '0;
    cv_rbit   = 1'b0;
    cv_sat    = 1'b0;
    cv_forced = 1'b0;
    cv_q      = '0;
    if (cv_e == 8'd0) begin
      cv_abs = '0;
    end else if (cv_e == 8'd255 && s1_r[22:0] != 23'd0) begin
      cv_sat    = 1'b1;
      cv_forced = 1'b1;
    end else if (cv_e >= 8'd142) begin
      cv_sat    = 1'b1;
      cv_forced = 1'b1;
      cv_q      = cv_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (cv_e >= 8'd134) begin
      cv_abs = {8'd0, cv_mag} << 3'(cv_e - 8'd134);
    end else if (cv_e >= 8'd110) begin
      // Round half away from zero: the sign is applied after rounding the magnitude.
      cv_shr  = {8'd0, cv_mag} >> 5'(8'd134 - cv_e);
      cv_rbit = cv_mag[5'(5'(8'd134 - cv_e) - 5'd1)];
      cv_abs  = cv_shr + {31'd0, cv_rbit};
    end
    if (!cv_forced) begin
      cv_q = cv_s ? (32'd0 - cv_abs) : cv_abs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v   <= 1'b0;
      s2_q   <= '0;
      s2_sat <= 1'b0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_q   <= cv_q;
        s2_sat <= cv_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s2_sat, s2_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign valid_out = (count != '0);
  assign q_out     = valid_out ? head[31:0] : '0;
  assign sat_out   = valid_out ? head[32] : 1'b0;
  assign busy      = s1_v | s2_v;

endmodule

// File: tb/tb_exp_fix_collector.sv
// Directed bench for exp_fix_collector: table of conversions with latency checks,
// plus backpressure, held-done, reset and drop-counter sequences.
module tb_exp_fix_collector;

  logic        clk;
  logic        reset;
  logic        done;
  logic [31:0] result;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] q_out;
  logic        sat_out;
  logic [7:0]  drop_cnt;
  logic        busy;

  int unsigned n_total;
  int unsigned n_pass;

  typedef struct {
    logic [31:0] r;
    logic [31:0] q;
    logic        sat;
  } vec_t;

  vec_t vecs [18];

  exp_fix_collector #(.FIFO_DEPTH(2), .DROP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .result    (result),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .q_out     (q_out),
    .sat_out   (sat_out),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int unsigned vcount;
    n_total   = 0;
    n_pass    = 0;
    reset     = 1'b1;
    done      = 1'b0;
    result    = '0;
    ready_out = 1'b1;

    vecs[0]  = '{32'h3F80_0000, 32'h0001_0000, 1'b0};
    vecs[1]  = '{32'h402D_F854, 32'h0002_B7E1, 1'b0};
    vecs[2]  = '{32'hBF00_0000, 32'hFFFF_8000, 1'b0};
    vecs[3]  = '{32'h3700_0000, 32'h0000_0001, 1'b0};
    vecs[4]  = '{32'h3380_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'h4974_2400, 32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1};
    vecs[8]  = '{32'h7FC0_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'h4000_0000, 32'h0002_0000, 1'b0};
    vecs[11] = '{32'h46FF_FE00, 32'h7FFF_0000, 1'b0};
    vecs[12] = '{32'h4700_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[13] = '{32'hC700_0000, 32'h8000_0000, 1'b1};
    vecs[14] = '{32'h3780_0000, 32'h0000_0001, 1'b0};
    vecs[15] = '{32'h3740_0000, 32'h0000_0001, 1'b0};
    vecs[16] = '{32'hB700_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[17] = '{32'h36FF_FFFF, 32'h0000_0000, 1'b0};

    tick();
    tick();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_q", q_out, 32'd0);
    check("rst_sat", {31'd0, sat_out}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      result = vecs[i].r;
      done   = 1'b1;
      tick();
      done = 1'b0;
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      tick();
      check($sformatf("v%0d_early", i), {31'd0, valid_out}, 32'd0);
      tick();
      check($sformatf("v%0d_valid", i), {31'd0, valid_out}, 32'd1);
      check($sformatf("v%0d_q", i), q_out, vecs[i].q);
      check($sformatf("v%0d_sat", i), {31'd0, sat_out}, {31'd0, vecs[i].sat});
      tick();
      check($sformatf("v%0d_popped", i), {31'd0, valid_out}, 32'd0);
    end

    // Backpressure: two buffered, two dropped, drained in order.
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      result = 32'h3F80_0000 + (i << 23);
      done   = 1'b1;
      tick();
      done = 1'b0;
      tick();
      tick();
      tick();
    end
    check("bp_drop", {24'd0, drop_cnt}, 32'd2);
    check("bp_valid", {31'd0, valid_out}, 32'd1);
    check("bp_head0", q_out, 32'h0001_0000);
    tick();
    check("bp_hold", q_out, 32'h0001_0000);
    ready_out = 1'b1;
    tick();
    check("bp_head1_valid", {31'd0, valid_out}, 32'd1);
    check("bp_head1", q_out, 32'h0002_0000);
    tick();
    check("bp_empty", {31'd0, valid_out}, 32'd0);
    check("bp_drop_keep", {24'd0, drop_cnt}, 32'd2);

    // done held high for 10 cycles yields a single entry.
    result = 32'h4000_0000;
    done   = 1'b1;
    vcount = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 10) done = 1'b0;
      tick();
      if (valid_out) begin
        vcount++;
        check("hold_q", q_out, 32'h0002_0000);
      end
    end
    check("hold_count", vcount, 32'd1);

    // Reset while S2 holds a result discards it.
    result = 32'h4040_0000;
    done   = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_valid", {31'd0, valid_out}, 32'd0);
    check("mid_busy_clr", {31'd0, busy}, 32'd0);
    check("mid_drop_clr", {24'd0, drop_cnt}, 32'd0);
    check("mid_q", q_out, 32'd0);
    reset  = 1'b0;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid_out) vcount++;
    end
    check("mid_no_entry", vcount, 32'd0);

    // Reset released with done high: one capture.
    reset  = 1'b1;
    result = 32'h4080_0000;
    done   = 1'b1;
    tick();
    reset  = 1'b0;
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid_out) begin
        vcount++;
        check("rel_q", q_out, 32'h0004_0000);
      end
    end
    check("rel_count", vcount, 32'd1);
    done = 1'b0;
    tick();

    // Drop counter saturates at all-ones.
    ready_out = 1'b0;
    for (int i = 0; i < 262; i++) begin
      result = 32'h3F80_0000;
      done   = 1'b1;
      tick();
      done = 1'b0;
      tick();
    end
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);
    check("drop_sat_valid", {31'd0, valid_out}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exp_fix_collector.md
# exp_fix_collector

Downstream stage of the floating-point exponential (Taylor/Horner) engine. It detects each completion of the engine's done level, captures the IEEE-754 single-precision result (the `1 + x*sum` value), and converts it to signed Q16.16 fixed point with round-to-nearest and saturation. It buffers up to two converted results in a FIFO for a valid/ready consumer, such as pixel/RGB scaling logic. When the buffer has no room, it drops results and counts them.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: output FIFO entries (power of two, ≥2).
- `DROP_W`, 8: width of the drop counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset. The clock/reset scheme (one clock, async active-high reset) is already decided.
- `done`  in  1  engine done level. It stays high while the engine holds its result.
- `result`  in  32  IEEE-754 single result. Valid whenever `done`=1.
- `ready_out`  in  1  consumer ready.
- `valid_out`  out  1  FIFO head valid.
- `q_out`  out  32  signed Q16.16 value at the FIFO head.
- `sat_out`  out  1  head entry was saturated or NaN-forced.
- `drop_cnt`  out  DROP_W  saturating count of dropped results.
- `busy`  out  1  a conversion is in flight (S1 or S2 valid).

## Operation
- **Edge detect:** register `done_d`. A capture request is `done & ~done_d`. Only one capture per high period of `done`.
- **Credit:** `occ = fifo_count + s1_v + s2_v − pop`, where `pop = valid_out & ready_out` in the same cycle.
  - Request with `occ < FIFO_DEPTH`: accept.
  - Otherwise: drop. `drop_cnt` increments and holds at all-ones.
- **S1 (capture):** latch `result`; set `s1_v`.
- **S2 (convert):** fields `s = r[31]`, `e = r[30:23]`, `mag = {1, r[22:0]}`. Value = mag·2^(e−134) in Q16.16 units.
  - `e = 0` (zero/denormal): result 0, sat 0.
  - `e = 255`, mantissa ≠ 0 (NaN): result 0, sat 1.
  - `e ≥ 142`, including infinity: result 0x7FFFFFFF if s = 0, else 0x80000000; sat 1.
  - `134 ≤ e ≤ 141`: mag << (e−134). Exact; cannot exceed 2^31−1.
  - `110 ≤ e ≤ 133`: mag >> (134−e), then round to nearest, ties away from zero. Add 1 if the last bit shifted out is 1.
  - `e ≤ 109`: result 0.
  - If s = 1, two's-complement negate. A negative zero yields 0.
- **FIFO push:** when `s2_v` is set, write `{sat, q}`. The credit rule guarantees the FIFO is never full at push time.
- **FIFO pop:** when `valid_out & ready_out`. Simultaneous push and pop is legal; count is unchanged.
- **Pointers:** wrap modulo `FIFO_DEPTH`.
- **Output:** `q_out`/`sat_out` reflect the head. They are stable while `valid_out` is high and `ready_out` is low.

## Timing
- **Reset values:** `valid_out`=0, `q_out`=0, `sat_out`=0, `drop_cnt`=0, `busy`=0. Also cleared: `done_d`, `s1_v`, `s2_v`, pointers, count.
- **Reset mid-operation:** in-flight and buffered results are discarded.
- **Reset release with `done` high:** `done_d` resets to 0, so one capture occurs on the first edge after release.
- **Latency:** `done` rise sampled at edge n → S1 at n → S2 at n+1 → FIFO write at n+2. `valid_out` is high after edge n+2 if the FIFO was empty.
- **Throughput:** one capture per two cycles maximum, since `done` must return low between captures.
- **No combinational path** from `done`/`result` to any output. `ready_out` affects only the next-cycle state.

## Test plan
- **Basic conversion:** pulse `done` with `result`=0x3F800000, `ready_out`=1 → `q_out`=0x00010000, `sat_out`=0, `valid_out` high for one cycle, 3 edges after the rise.
- **e and negative input:** `result`=0x402DF854 (e) → `q_out`=0x0002B7E1. `result`=0xBF000000 → `q_out`=0xFFFF8000.
- **Rounding and underflow:**
  - 0x37000000 (2^−17, tie) → 0x00000001.
  - 0x33800000 → 0x00000000.
  - 0x00000001 (denormal) → 0, sat 0.
- **Saturation:**
  - 0x49742400 (1e6) → 0x7FFFFFFF, sat 1.
  - 0xFF800000 (−inf) → 0x80000000, sat 1.
  - 0x7FC00000 (NaN) → 0, sat 1.
- **Backpressure:** hold `ready_out`=0 and issue 4 `done` pulses of distinct values → first 2 are buffered, `drop_cnt`=2. Release `ready_out` → the first 2 values come out in order, then `valid_out`=0.
- **Hold and reset:** hold `done` high for 10 cycles → exactly one entry. Assert `reset` while S2 is valid → all outputs 0 on the next edge, no entry appears after release.
